vx_fpu_fflags_csr: RTL and testbench
====================================

// Module: vx_fpu_fflags_csr
// PURPOSE
//  Consumer end of the FPU fflags_t interface: gathers per-lane exception flags from FPU
//  commits, OR-reduces them over active lanes and accumulates them sticky into per-warp
//  fflags CSRs. Holds per-warp frm, serves fflags/frm/fcsr CSR read/write/set/clear.
//  Sits between FPU commit and CSR unit.
// PARAMETERS
//  NUM_WARPS  4   warps with private fcsr state; WID_W = max(1,$clog2(NUM_WARPS))
//  NUM_LANES  4   lanes per commit
// PORTS
//  clk               in   1             clock
//  reset             in   1             synchronous, active-high
//  commit_valid      in   1             FPU commit beat valid
//  commit_ready      out  1             commit accepted when valid&ready
//  commit_wid        in   WID_W         warp of commit
//  commit_tmask      in   NUM_LANES     active lanes
//  commit_has_fflags in   1             op writes fflags (0: beat consumed, no update)
//  commit_fflags     in   NUM_LANES*5   per-lane fflags_t {NV,DZ,OF,UF,NX}, lane0 in LSBs
//  csr_req_valid     in   1             CSR request
//  csr_req_ready     out  1             request accepted when valid&ready
//  csr_req_wid       in   WID_W         target warp
//  csr_req_op        in   2             0 READ, 1 WRITE, 2 SET, 3 CLEAR
//  csr_req_addr      in   2             0 FFLAGS(5b), 1 FRM(3b), 2 FCSR({frm,fflags} 8b), 3 rsvd
//  csr_req_data      in   8             write/set/clear operand, LSB-aligned
//  csr_rsp_valid     out  1             response, exactly 1 cycle after accept
//  csr_rsp_data      out  8             old value of addressed field, zero-extended
//  frm_wid           in   WID_W         rounding-mode lookup warp
//  frm_out           out  3             frm[frm_wid], combinational from register
// BEHAVIOUR
//  - Reset: all fflags=0, frm=0 (RNE), S1/S2 valid=0, csr_rsp_valid=0, csr_rsp_data=0.
//    In-flight commits dropped; reset over any cycle wins over all updates.
//  - commit_ready = ~reset (never back-pressures).
//  - S1 (accept edge): reg wid, red = OR over lanes i with tmask[i] of fflags[i];
//    S1.valid = commit_valid & has_fflags & (tmask!=0).
//  - S2: reg S1. On S2.valid, fflags[S2.wid] |= S2.red. Visible to READ 2 cycles after accept.
//  - csr_req_ready = ~reset & ~(S1.valid & S1.wid==csr_req_wid) & ~(S2.valid & S2.wid==csr_req_wid):
//    CSR ops ordered after all earlier commits of that warp; stall is at most 2 cycles.
//  - Accepted CSR op, field F of warp W, mask M (FFLAGS 0x1F, FRM 0x07 of data[7:5] for FCSR):
//    WRITE F=data; SET F|=data; CLEAR F&=~data; READ no change. Addr 3: no-op, rsp 0.
//    FCSR splits data[4:0]->fflags, data[7:5]->frm. Unused upper data bits ignored.
//  - Same-cycle same-warp collision cannot occur (stall rule); different warps update in parallel.
//  - Commit accepted same cycle as CSR op of same warp: commit is younger, enters S1 after CSR.
//  - csr_rsp_data = pre-update value; rsp_valid pulses 1 cycle, no back-pressure on response.
//  - frm_out reflects CSR write 1 cycle after accept; out-of-range wid (non-pow2 NUM_WARPS)
//    returns 0 and requests to it are accepted as no-ops.
// STRUCTURE
//  - Shared pkg (fpu types): fflags_t, fclass_t, FP_FLAGS_BITS; add csr_op_e {READ,WRITE,SET,
//    CLEAR}, csr_fpu_addr_e {FFLAGS,FRM,FCSR}, frm_e (RNE=0,RTZ,RDN,RUP,RMM).
//  - Sub-module vx_fflags_reduce: combinational masked OR of NUM_LANES fflags_t -> fflags_t.
//  - Storage: NUM_WARPS x {frm[2:0], fflags_t} flops, no RAM.
// TESTING
//  1 Reset then READ FCSR w0..w3 -> rsp 0x00 each, exactly 1 cycle after accept.
//  2 Commit w1 tmask=0101, lane0 NX, lane1 DZ, lane2 OF -> after 2 cycles READ FFLAGS w1 = 0x05
//    (lane1 masked); other warps 0.
//  3 Commit w2 NV then READ w2 next cycle -> ready low 2 cycles, rsp 0x10; again with
//    has_fflags=0 -> no stall, rsp 0x00.
//  4 FCSR WRITE 0xE3 w0 -> frm_out(w0)=7 next cycle, READ FFLAGS=0x03; SET FFLAGS 0x08 ->
//    rsp 0x03, then 0x0B; CLEAR FCSR 0xE1 -> FCSR=0x0A.
//  5 Back-to-back commits every cycle alternating w0/w3 with CSR READs to w1 -> no stalls,
//    w1 unchanged, final w0/w3 = OR of their streams.
//  6 Reset asserted with S1,S2 holding flags for w0 -> post-reset READ w0 = 0x00, rsp_valid 0 during reset.

Source files
------------

// File: rtl/vx_fpu_fflags_csr_pkg.sv
// rtl/vx_fpu_fflags_csr_pkg.sv - shared FPU types and fcsr helpers
// Purpose: fflags/fclass types, fcsr op/address/rounding-mode enums, width helper
//          and the read-modify-write rule shared by the fcsr fields.
// Ports: none (package).
package vx_fpu_fflags_csr_pkg;

  localparam int FP_FLAGS_BITS = 5;

  // Bit order {NV,DZ,OF,UF,NX}: NX is bit 0, NV is bit 4.
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  typedef struct packed {
    logic is_normal;
    logic is_zero;
    logic is_subnormal;
    logic is_inf;
    logic is_nan;
    logic is_quiet;
    logic is_signaling;
  } fclass_t;

  typedef enum logic [1:0] {
    CSR_READ  = 2'd0,
    CSR_WRITE = 2'd1,
    CSR_SET   = 2'd2,
    CSR_CLEAR = 2'd3
  } csr_op_e;

  // Address 3 is reserved and decodes to a no-op.
  typedef enum logic [1:0] {
    CSR_FFLAGS = 2'd0,
    CSR_FRM    = 2'd1,
    CSR_FCSR   = 2'd2
  } csr_fpu_addr_e;

  typedef enum logic [2:0] {
    FRM_RNE = 3'd0,
    FRM_RTZ = 3'd1,
    FRM_RDN = 3'd2,
    FRM_RUP = 3'd3,
    FRM_RMM = 3'd4
  } frm_e;

  function automatic int fpu_wid_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Operands are zero-extended to 8 bits by the caller, so bits outside the
  // addressed field stay zero for SET/CLEAR and are simply dropped afterwards.
  function automatic logic [7:0] fpu_csr_apply(input logic [1:0] op,
                                               input logic [7:0] cur,
                                               input logic [7:0] opnd);
    case (op)
      CSR_WRITE: return opnd;
      CSR_SET:   return cur | opnd;
      CSR_CLEAR: return cur & ~opnd;
      default:   return cur;
    endcase
  endfunction

endpackage

// File: rtl/vx_fpu_fflags_csr_if.sv
// rtl/vx_fpu_fflags_csr_if.sv - commit, CSR and frm lookup bus of the fflags CSR block
// Purpose: bundles the FPU commit beat, the CSR request/response pair and the
//          rounding-mode lookup.
// Modports: master = FPU commit source + CSR unit, slave = vx_fpu_fflags_csr.
interface vx_fpu_fflags_csr_if #(
  parameter int NUM_WARPS = 4,
  parameter int NUM_LANES = 4
);
  import vx_fpu_fflags_csr_pkg::*;

  localparam int WID_W = fpu_wid_w(NUM_WARPS);

  logic                                 commit_valid;
  logic                                 commit_ready;
  logic [WID_W-1:0]                     commit_wid;
  logic [NUM_LANES-1:0]                 commit_tmask;
  logic                                 commit_has_fflags;
  logic [NUM_LANES*FP_FLAGS_BITS-1:0]   commit_fflags;

  logic                                 csr_req_valid;
  logic                                 csr_req_ready;
  logic [WID_W-1:0]                     csr_req_wid;
  logic [1:0]                           csr_req_op;
  logic [1:0]                           csr_req_addr;
  logic [7:0]                           csr_req_data;
  logic                                 csr_rsp_valid;
  logic [7:0]                           csr_rsp_data;

  logic [WID_W-1:0]                     frm_wid;
  logic [2:0]                           frm_out;

  modport master (
    output commit_valid, commit_wid, commit_tmask, commit_has_fflags, commit_fflags,
    output csr_req_valid, csr_req_wid, csr_req_op, csr_req_addr, csr_req_data,
    output frm_wid,
    input  commit_ready, csr_req_ready, csr_rsp_valid, csr_rsp_data, frm_out
  );

  modport slave (
    input  commit_valid, commit_wid, commit_tmask, commit_has_fflags, commit_fflags,
    input  csr_req_valid, csr_req_wid, csr_req_op, csr_req_addr, csr_req_data,
    input  frm_wid,
    output commit_ready, csr_req_ready, csr_rsp_valid, csr_rsp_data, frm_out
  );

endinterface

// File: rtl/vx_fflags_reduce.sv
// rtl/vx_fflags_reduce.sv - masked OR of per-lane exception flags
// Purpose: combinational OR of the fflags of every active lane.
// Ports: tmask_i  active lanes
//        fflags_i per-lane flags, lane 0 in the LSBs
//        fflags_o OR over active lanes
module vx_fflags_reduce
  import vx_fpu_fflags_csr_pkg::*;
#(
  parameter int NUM_LANES = 4
) (
  input  logic [NUM_LANES-1:0]               tmask_i,
  input  logic [NUM_LANES*FP_FLAGS_BITS-1:0] fflags_i,
  output fflags_t                            fflags_o
);

  logic [FP_FLAGS_BITS-1:0] acc;

  always_comb begin
    acc = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (tmask_i[i]) acc = acc | fflags_i[i*FP_FLAGS_BITS +: FP_FLAGS_BITS];
    end
    fflags_o = acc;
  end

endmodule

// File: rtl/vx_fpu_fflags_csr.sv
// rtl/vx_fpu_fflags_csr.sv - per-warp sticky fflags accumulation and fcsr CSR access
// Purpose: reduces FPU commit flags over active lanes, accumulates them into
//          per-warp fflags through a two-stage pipe, and serves fflags/frm/fcsr
//          READ/WRITE/SET/CLEAR with a one-cycle response.
// Ports: clk, reset  clock, synchronous active-high reset
//        bus         vx_fpu_fflags_csr_if.slave (commit, CSR req/rsp, frm lookup)
module vx_fpu_fflags_csr #(
  parameter int NUM_WARPS = 4,
  parameter int NUM_LANES = 4
) (
  input  logic               clk,
  input  logic               reset,
  vx_fpu_fflags_csr_if.slave bus
);
  import vx_fpu_fflags_csr_pkg::*;

  localparam int WID_W = fpu_wid_w(NUM_WARPS);
  localparam logic [WID_W:0] NW = (WID_W + 1)'(NUM_WARPS);

  fflags_t          commit_red;
  logic             s1_valid_q, s2_valid_q;
  logic [WID_W-1:0] s1_wid_q, s2_wid_q;
  fflags_t          s1_red_q, s2_red_q;

  logic [4:0]       fflags_q [NUM_WARPS];
  logic [4:0]       fflags_d [NUM_WARPS];
  logic [2:0]       frm_q    [NUM_WARPS];
  logic [2:0]       frm_d    [NUM_WARPS];

  logic             csr_ready, csr_fire, csr_wid_ok;
  logic [4:0]       ff_sel, new_ff;
  logic [2:0]       frm_sel, new_frm;
  logic [7:0]       csr_old, csr_upd;
  logic             rsp_valid_q;
  logic [7:0]       rsp_data_q;

  vx_fflags_reduce #(.NUM_LANES(NUM_LANES)) u_reduce (
    .tmask_i  (bus.commit_tmask),
    .fflags_i (bus.commit_fflags),
    .fflags_o (commit_red)
  );

  // Commit pipe. Beats without flags or active lanes never enter it, so they
  // neither update state nor stall the CSR port.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_wid_q   <= '0;
      s2_wid_q   <= '0;
      s1_red_q   <= '0;
      s2_red_q   <= '0;
    end else begin
      s1_valid_q <= bus.commit_valid & bus.commit_has_fflags & (|bus.commit_tmask);
      s1_wid_q   <= bus.commit_wid;
      s1_red_q   <= commit_red;
      s2_valid_q <= s1_valid_q;
      s2_wid_q   <= s1_wid_q;
      s2_red_q   <= s1_red_q;
    end
  end

  // Holding a CSR op while its warp has a commit in flight orders it after
  // that commit and rules out a same-warp CSR/commit write in one cycle.
  assign csr_ready = ~reset
                   & ~(s1_valid_q && (s1_wid_q == bus.csr_req_wid))
                   & ~(s2_valid_q && (s2_wid_q == bus.csr_req_wid));
  assign csr_fire  = bus.csr_req_valid & csr_ready;
  assign csr_wid_ok = ({1'b0, bus.csr_req_wid} < NW);

  assign bus.commit_ready  = ~reset;
  assign bus.csr_req_ready = csr_ready;
  assign bus.csr_rsp_valid = rsp_valid_q;
  assign bus.csr_rsp_data  = rsp_data_q;
  assign bus.frm_out       = ({1'b0, bus.frm_wid} < NW) ? frm_q[bus.frm_wid] : 3'd0;

  // Old value and updated fields of the addressed warp; out-of-range warps read as 0.
  always_comb begin
    ff_sel  = csr_wid_ok ? fflags_q[bus.csr_req_wid] : 5'd0;
    frm_sel = csr_wid_ok ? frm_q[bus.csr_req_wid] : 3'd0;
    csr_old = 8'h00;
    csr_upd = 8'h00;
    new_ff  = ff_sel;
    new_frm = frm_sel;
    case (bus.csr_req_addr)
      CSR_FFLAGS: begin
        csr_old = {3'b000, ff_sel};
        csr_upd = fpu_csr_apply(bus.csr_req_op, csr_old, {3'b000, bus.csr_req_data[4:0]});
        new_ff  = csr_upd[4:0];
      end
      CSR_FRM: begin
        csr_old = {5'b00000, frm_sel};
        csr_upd = fpu_csr_apply(bus.csr_req_op, csr_old, {5'b00000, bus.csr_req_data[2:0]});
        new_frm = csr_upd[2:0];
      end
      CSR_FCSR: begin
        csr_old = {frm_sel, ff_sel};
        csr_upd = fpu_csr_apply(bus.csr_req_op, csr_old, bus.csr_req_data);
        new_ff  = csr_upd[4:0];
        new_frm = csr_upd[7:5];
      end
      default: ;
    endcase
  end

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      fflags_d[w] = fflags_q[w];
      frm_d[w]    = frm_q[w];
      if (s2_valid_q && (s2_wid_q == WID_W'(w))) fflags_d[w] = fflags_q[w] | s2_red_q;
      if (csr_fire && (bus.csr_req_wid == WID_W'(w))) begin
        fflags_d[w] = new_ff;
        frm_d[w]    = new_frm;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        fflags_q[w] <= '0;
        frm_q[w]    <= FRM_RNE;
      end
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        fflags_q[w] <= fflags_d[w];
        frm_q[w]    <= frm_d[w];
      end
      rsp_valid_q <= csr_fire;
      if (csr_fire) rsp_data_q <= csr_old;
    end
  end

endmodule

// File: tb/tb_vx_fpu_fflags_csr.sv
// tb/tb_vx_fpu_fflags_csr.sv - self-checking bench for vx_fpu_fflags_csr
module tb_vx_fpu_fflags_csr;
  import vx_fpu_fflags_csr_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vx_fpu_fflags_csr_if #(.NUM_WARPS(4), .NUM_LANES(4)) bus ();

  vx_fpu_fflags_csr #(.NUM_WARPS(4), .NUM_LANES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: flags land in the model the moment a commit is accepted.
  // That is observably exact because CSR ops of that warp wait for the commit.
  logic [4:0] m_ff  [4];
  logic [2:0] m_frm [4];
  logic       p1v = 1'b0, p2v = 1'b0;
  logic [1:0] p1w = '0, p2w = '0;
  logic       last_ready;
  logic [7:0] last_rsp;

  typedef struct {
    logic [1:0] op;
    logic [1:0] addr;
    logic [1:0] wid;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_apply(input logic [1:0] op, input logic [7:0] cur,
                                           input logic [7:0] arg);
    if (op == CSR_WRITE) return arg;
    if (op == CSR_SET)   return cur | arg;
    if (op == CSR_CLEAR) return cur & ~arg;
    return cur;
  endfunction

  function automatic vec_t mk(input logic [1:0] op, input logic [1:0] addr, input logic [1:0] wid,
                              input logic [7:0] data, input logic [7:0] exp);
    vec_t v;
    v.op = op; v.addr = addr; v.wid = wid; v.data = data; v.exp = exp;
    return v;
  endfunction

  task automatic set_commit(input logic v, input logic [1:0] w, input logic [3:0] tm,
                            input logic has, input logic [19:0] fl);
    bus.commit_valid = v; bus.commit_wid = w; bus.commit_tmask = tm;
    bus.commit_has_fflags = has; bus.commit_fflags = fl;
  endtask

  task automatic set_csr(input logic v, input logic [1:0] op, input logic [1:0] addr,
                         input logic [1:0] w, input logic [7:0] d);
    bus.csr_req_valid = v; bus.csr_req_op = op; bus.csr_req_addr = addr;
    bus.csr_req_wid = w; bus.csr_req_data = d;
  endtask

  // One clock: check combinational outputs mid-cycle, advance the model,
  // then check the registered response just after the edge.
  task automatic cycle();
    logic       exp_ready, fire, cm;
    logic [7:0] old, upd, d;
    logic [4:0] red;
    int         w;
    @(negedge clk);
    exp_ready = !reset && !(p1v && p1w == bus.csr_req_wid) && !(p2v && p2w == bus.csr_req_wid);
    check("csr_req_ready", bus.csr_req_ready, exp_ready);
    check("commit_ready", bus.commit_ready, !reset);
    check("frm_out", bus.frm_out, m_frm[bus.frm_wid]);
    last_ready = bus.csr_req_ready;
    fire = bus.csr_req_valid && exp_ready;
    old = 8'h00;
    if (fire) begin
      w = int'(bus.csr_req_wid);
      d = bus.csr_req_data;
      case (bus.csr_req_addr)
        2'd0: begin
          old = {3'b000, m_ff[w]};
          upd = ref_apply(bus.csr_req_op, old, {3'b000, d[4:0]});
          m_ff[w] = upd[4:0];
        end
        2'd1: begin
          old = {5'b00000, m_frm[w]};
          upd = ref_apply(bus.csr_req_op, old, {5'b00000, d[2:0]});
          m_frm[w] = upd[2:0];
        end
        2'd2: begin
          old = {m_frm[w], m_ff[w]};
          upd = ref_apply(bus.csr_req_op, old, d);
          m_frm[w] = upd[7:5];
          m_ff[w]  = upd[4:0];
        end
        default: old = 8'h00;
      endcase
    end
    cm = !reset && bus.commit_valid && bus.commit_has_fflags && (bus.commit_tmask != 4'd0);
    if (cm) begin
      red = 5'd0;
      for (int i = 0; i < 4; i++)
        if (bus.commit_tmask[i]) red = red | bus.commit_fflags[i*5 +: 5];
      m_ff[bus.commit_wid] = m_ff[bus.commit_wid] | red;
    end
    p2v = p1v; p2w = p1w;
    p1v = cm;  p1w = bus.commit_wid;
    if (reset) begin
      for (int k = 0; k < 4; k++) begin m_ff[k] = 5'd0; m_frm[k] = 3'd0; end
      p1v = 1'b0; p2v = 1'b0;
    end
    @(posedge clk);
    #1;
    check("csr_rsp_valid", bus.csr_rsp_valid, fire);
    if (fire) check("csr_rsp_data", bus.csr_rsp_data, old);
    if (reset) check("rsp_data_reset", bus.csr_rsp_data, 8'h00);
    last_rsp = bus.csr_rsp_data;
  endtask

  task automatic csr_op(input logic [1:0] op, input logic [1:0] addr, input logic [1:0] w,
                        input logic [7:0] d, output logic [7:0] rsp, output int stalls);
    logic done;
    done = 1'b0;
    stalls = 0;
    rsp = 8'h00;
    set_commit(1'b0, 2'd0, 4'd0, 1'b0, 20'd0);
    set_csr(1'b1, op, addr, w, d);
    for (int i = 0; i < 8 && !done; i++) begin
      cycle();
      if (last_ready) begin done = 1'b1; rsp = last_rsp; end
      else stalls++;
    end
    bus.csr_req_valid = 1'b0;
    check("csr_accept_bound", done, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  rsp;
    int          st;
    logic [4:0]  acc0, acc3;
    logic [19:0] fl;
    logic [1:0]  cw;

    for (int k = 0; k < 4; k++) begin m_ff[k] = 5'd0; m_frm[k] = 3'd0; end
    set_commit(1'b0, 2'd0, 4'd0, 1'b0, 20'd0);
    set_csr(1'b0, 2'd0, 2'd0, 2'd0, 8'h00);
    bus.frm_wid = 2'd0;
    reset = 1'b1;
    cycle();
    cycle();
    check("reset_rsp_valid", bus.csr_rsp_valid, 1'b0);
    check("reset_rsp_data", bus.csr_rsp_data, 8'h00);
    check("reset_frm_out", bus.frm_out, 3'd0);
    reset = 1'b0;

    // Masked lane reduction: lane1 DZ is outside the mask.
    set_commit(1'b1, 2'd1, 4'b0101, 1'b1, {5'h00, 5'h04, 5'h08, 5'h01});
    cycle();
    set_commit(1'b0, 2'd0, 4'd0, 1'b0, 20'd0);
    cycle();
    cycle();
    csr_op(CSR_READ, CSR_FFLAGS, 2'd1, 8'h00, rsp, st);
    check("mask_w1_flags", rsp, 8'h05);
    check("mask_w1_stall", st, 0);
    for (int k = 0; k < 4; k++) begin
      if (k != 1) begin
        csr_op(CSR_READ, CSR_FCSR, 2'(k), 8'h00, rsp, st);
        check("mask_other_warp", rsp, 8'h00);
      end
    end

    // A read right behind a flagged commit of its warp stalls exactly 2 cycles.
    set_commit(1'b1, 2'd2, 4'b0001, 1'b1, 20'h00010);
    cycle();
    csr_op(CSR_READ, CSR_FFLAGS, 2'd2, 8'h00, rsp, st);
    check("stall_nv_rsp", rsp, 8'h10);
    check("stall_nv_cycles", st, 2);
    csr_op(CSR_CLEAR, CSR_FFLAGS, 2'd2, 8'h1F, rsp, st);
    check("clear_w2_old", rsp, 8'h10);
    set_commit(1'b1, 2'd2, 4'b0001, 1'b0, 20'h00010);
    cycle();
    csr_op(CSR_READ, CSR_FFLAGS, 2'd2, 8'h00, rsp, st);
    check("noflags_rsp", rsp, 8'h00);
    check("noflags_stall", st, 0);
    set_commit(1'b1, 2'd2, 4'b0000, 1'b1, 20'hFFFFF);
    cycle();
    csr_op(CSR_READ, CSR_FFLAGS, 2'd2, 8'h00, rsp, st);
    check("zero_tmask_rsp", rsp, 8'h00);
    check("zero_tmask_stall", st, 0);

    // Table of CSR operations from a clean state.
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    tbl.push_back(mk(CSR_READ,  CSR_FCSR,   2'd0, 8'h00, 8'h00));
    tbl.push_back(mk(CSR_READ,  CSR_FCSR,   2'd1, 8'h00, 8'h00));
    tbl.push_back(mk(CSR_READ,  CSR_FCSR,   2'd2, 8'h00, 8'h00));
    tbl.push_back(mk(CSR_READ,  CSR_FCSR,   2'd3, 8'h00, 8'h00));
    tbl.push_back(mk(CSR_WRITE, CSR_FCSR,   2'd0, 8'hE3, 8'h00));
    tbl.push_back(mk(CSR_READ,  CSR_FFLAGS, 2'd0, 8'h00, 8'h03));
    tbl.push_back(mk(CSR_READ,  CSR_FRM,    2'd0, 8'h00, 8'h07));
    tbl.push_back(mk(CSR_SET,   CSR_FFLAGS, 2'd0, 8'h08, 8'h03));
    tbl.push_back(mk(CSR_READ,  CSR_FFLAGS, 2'd0, 8'h00, 8'h0B));
    tbl.push_back(mk(CSR_CLEAR, CSR_FCSR,   2'd0, 8'hE1, 8'hEB));
    tbl.push_back(mk(CSR_READ,  CSR_FCSR,   2'd0, 8'h00, 8'h0A));
    tbl.push_back(mk(CSR_WRITE, CSR_FFLAGS, 2'd1, 8'hFF, 8'h00));
    tbl.push_back(mk(CSR_READ,  CSR_FCSR,   2'd1, 8'h00, 8'h1F));
    tbl.push_back(mk(CSR_WRITE, CSR_FRM,    2'd2, 8'hFC, 8'h00));
    tbl.push_back(mk(CSR_READ,  CSR_FCSR,   2'd2, 8'h00, 8'h80));
    tbl.push_back(mk(CSR_SET,   CSR_FRM,    2'd2, 8'h03, 8'h04));
    tbl.push_back(mk(CSR_READ,  CSR_FRM,    2'd2, 8'h00, 8'h07));
    tbl.push_back(mk(CSR_CLEAR, CSR_FRM,    2'd2, 8'h05, 8'h07));
    tbl.push_back(mk(CSR_READ,  CSR_FCSR,   2'd2, 8'h00, 8'h40));
    tbl.push_back(mk(CSR_WRITE, 2'd3,       2'd3, 8'hFF, 8'h00));
    tbl.push_back(mk(CSR_READ,  CSR_FCSR,   2'd3, 8'h00, 8'h00));
    foreach (tbl[i]) begin
      bus.frm_wid = tbl[i].wid;
      csr_op(tbl[i].op, tbl[i].addr, tbl[i].wid, tbl[i].data, rsp, st);
      check($sformatf("tbl%0d", i), rsp, tbl[i].exp);
    end
    bus.frm_wid = 2'd0;
    cycle();
    check("frm_w0_after_clear", bus.frm_out, 3'd0);

    // Back-to-back commits to w0/w3 while w1 is read every cycle.
    csr_op(CSR_WRITE, CSR_FFLAGS, 2'd0, 8'h00, rsp, st);
    csr_op(CSR_WRITE, CSR_FFLAGS, 2'd3, 8'h00, rsp, st);
    csr_op(CSR_WRITE, CSR_FFLAGS, 2'd1, 8'h15, rsp, st);
    acc0 = 5'd0;
    acc3 = 5'd0;
    for (int k = 0; k < 20; k++) begin
      fl = 20'($urandom) & 20'h08421;
      fl = fl << $urandom_range(0, 4);
      cw = (k % 2 == 0) ? 2'd0 : 2'd3;
      for (int i = 0; i < 4; i++) begin
        if (cw == 2'd0) acc0 = acc0 | fl[i*5 +: 5];
        else            acc3 = acc3 | fl[i*5 +: 5];
      end
      set_commit(1'b1, cw, 4'hF, 1'b1, fl);
      set_csr(1'b1, CSR_READ, CSR_FFLAGS, 2'd1, 8'h00);
      cycle();
      check("b2b_no_stall", last_ready, 1'b1);
      check("b2b_w1_unchanged", last_rsp, 8'h15);
    end
    bus.csr_req_valid = 1'b0;
    csr_op(CSR_READ, CSR_FFLAGS, 2'd0, 8'h00, rsp, st);
    check("b2b_w0_or", rsp, {3'b000, acc0});
    csr_op(CSR_READ, CSR_FFLAGS, 2'd3, 8'h00, rsp, st);
    check("b2b_w3_or", rsp, {3'b000, acc3});

    // Randomized traffic against the model, with occasional resets.
    for (int k = 0; k < 400; k++) begin
      reset = ($urandom_range(0, 79) == 0);
      set_commit($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 4'($urandom),
                 $urandom_range(0, 3) != 0, 20'($urandom));
      set_csr($urandom_range(0, 1) == 1, 2'($urandom), 2'($urandom),
              2'($urandom_range(0, 3)), 8'($urandom));
      bus.frm_wid = 2'($urandom_range(0, 3));
      cycle();
    end
    reset = 1'b0;
    set_csr(1'b0, 2'd0, 2'd0, 2'd0, 8'h00);

    // Reset while S1 and S2 both carry flags for w0.
    csr_op(CSR_WRITE, CSR_FCSR, 2'd0, 8'h00, rsp, st);
    set_commit(1'b1, 2'd0, 4'hF, 1'b1, 20'h00010);
    cycle();
    set_commit(1'b1, 2'd0, 4'hF, 1'b1, 20'h00004);
    cycle();
    set_commit(1'b0, 2'd0, 4'd0, 1'b0, 20'd0);
    set_csr(1'b1, CSR_READ, CSR_FCSR, 2'd0, 8'h00);
    reset = 1'b1;
    cycle();
    check("rst_ready_low", last_ready, 1'b0);
    check("rst_rsp_valid", bus.csr_rsp_valid, 1'b0);
    reset = 1'b0;
    bus.csr_req_valid = 1'b0;
    cycle();
    cycle();
    csr_op(CSR_READ, CSR_FCSR, 2'd0, 8'h00, rsp, st);
    check("rst_w0_cleared", rsp, 8'h00);
    check("rst_w0_no_stall", st, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
